id_stage_p: RTL and testbench

Parametrised instruction-decode pipeline stage for the R/I/J CPU, placed between the IF stage and the EX stage. It holds an internal register file with write-back port and selects the immediate extension mode from the opcode. It registers NPC/IR/A/B/Imm into a valid/ready pipeline slot and detects load-use hazards against EX, inserting bubbles as needed. An optional write-back bypass covers same-cycle read-after-write.

---
 rtl/id_stage_p.sv | 179 +++++++++++++++++
 tb/tb_id_stage_p.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_p.sv
// rtl/id_stage_p.sv - instruction-decode pipeline stage with register file, immediate extension and load-use interlock
//
// Purpose
//    Sits between IF and EX. Decodes rs/rt from the offered instruction,
//    reads them from the internal register file, extends the immediate
//    according to the opcode and captures NPC/IR/A/B/Imm into a single
//    valid/ready output slot. A load in EX whose destination matches rs or rt
//    holds the offered instruction at the input and lets a bubble through.
//
// Configuration
//    ID_WB_BYPASS_EN  defined   : a write-back landing on the capture/refresh
//                                 edge is forwarded into A/B directly.
//                     undefined : a write-back colliding with the offered rs/rt
//                                 stalls the input for one cycle instead, so the
//                                 value is read from the file on the next cycle.
//
// Parameters
//    XLEN       datapath width (>= 32)
//    REG_COUNT  architectural registers, power of two, <= 32
//    ZERO_REG   1 = register 0 reads as zero and ignores writes
//
// Ports
//    clk, rst                clock (posedge), asynchronous active-low reset
//    in_valid/in_ready       instruction offer from IF and its acceptance
//    in_npc, in_ir           next PC and instruction word offered by IF
//    out_valid/out_ready     output slot handshake towards EX
//    flush                   kill the slot and the offer (taken branch)
//    ex_load, ex_rd          EX holds a load writing ex_rd
//    wb_we, wb_addr, wb_data register-file write-back port
//    npc_o, ir_o             captured next PC and instruction
//    a_o, b_o, imm_o         rs value, rt value, extended immediate

module id_stage_p #(
   parameter int XLEN      = 32,
   parameter int REG_COUNT = 32,
   parameter int ZERO_REG  = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_npc,
   input  logic [31:0]     in_ir,
   output logic            out_valid,
   input  logic            out_ready,
   input  logic            flush,
   input  logic            ex_load,
   input  logic [4:0]      ex_rd,
   input  logic            wb_we,
   input  logic [4:0]      wb_addr,
   input  logic [XLEN-1:0] wb_data,
   output logic [XLEN-1:0] npc_o,
   output logic [XLEN-1:0] a_o,
   output logic [XLEN-1:0] b_o,
   output logic [XLEN-1:0] imm_o,
   output logic [31:0]     ir_o
);

   localparam int RAW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

   logic [XLEN-1:0] regs [REG_COUNT];

   logic [RAW-1:0]  wb_idx;
   logic            wb_write;
   logic            hold;
   logic [RAW-1:0]  in_rs_idx;
   logic [RAW-1:0]  in_rt_idx;
   logic [RAW-1:0]  sel_rs_idx;
   logic [RAW-1:0]  sel_rt_idx;
   logic [XLEN-1:0] rd_a;
   logic [XLEN-1:0] rd_b;
   logic [XLEN-1:0] imm_ext;
   logic            ld_hz;
   logic            col_hz;
   logic            hz;
   logic            accept;

   // Write-back: bits of wb_addr above RAW are ignored; register 0 is
   // write-protected when ZERO_REG is set.
   assign wb_idx   = wb_addr[RAW-1:0];
   assign wb_write = wb_we & ~((ZERO_REG != 0) && (wb_idx == '0));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < REG_COUNT; i++) begin
            regs[i] <= '0;
         end
      end else if (wb_write) begin
         regs[wb_idx] <= wb_data;
      end
   end

   // The slot is held when it is live and EX is not taking it. While held no
   // instruction can be accepted, so the single pair of read ports is steered
   // to the held instruction's rs/rt to refresh A/B; otherwise it serves the
   // offered instruction for capture.
   assign hold       = out_valid & ~out_ready;
   assign in_rs_idx  = in_ir[21 +: RAW];
   assign in_rt_idx  = in_ir[16 +: RAW];
   assign sel_rs_idx = hold ? ir_o[21 +: RAW] : in_rs_idx;
   assign sel_rt_idx = hold ? ir_o[16 +: RAW] : in_rt_idx;

   always_comb begin
      rd_a = regs[sel_rs_idx];
      rd_b = regs[sel_rt_idx];
      if ((ZERO_REG != 0) && (sel_rs_idx == '0)) begin
         rd_a = '0;
      end
      if ((ZERO_REG != 0) && (sel_rt_idx == '0)) begin
         rd_b = '0;
      end
`ifdef ID_WB_BYPASS_EN
      // wb_write already excludes a protected register 0, so the forward
      // never overrides the hard zero.
      if (wb_write && (wb_idx == sel_rs_idx)) begin
         rd_a = wb_data;
      end
      if (wb_write && (wb_idx == sel_rt_idx)) begin
         rd_b = wb_data;
      end
`endif
   end

   // Immediate extension selected by opcode: logical ops zero-extend, lui
   // shifts into the upper half, everything else sign-extends.
   always_comb begin
      imm_ext = '0;
      case (in_ir[31:26])
         6'h0C, 6'h0D, 6'h0E: imm_ext[15:0] = in_ir[15:0];
         6'h0F:               imm_ext[31:16] = in_ir[15:0];
         default:             imm_ext = {{(XLEN-16){in_ir[15]}}, in_ir[15:0]};
      endcase
   end

   // Load-use compares the full 5-bit register fields against ex_rd.
   assign ld_hz = in_valid & ex_load & (ex_rd != 5'd0) &
                  ((ex_rd == in_ir[25:21]) | (ex_rd == in_ir[20:16]));

`ifdef ID_WB_BYPASS_EN
   assign col_hz = 1'b0;
`else
   // Without forwarding, a write landing on the capture edge would be missed;
   // stall one cycle so the file holds the new value on the next read.
   assign col_hz = in_valid & wb_write &
                   ((wb_idx == in_rs_idx) | (wb_idx == in_rt_idx));
`endif

   assign hz       = ld_hz | col_hz;
   assign in_ready = ~hz & (~out_valid | out_ready);
   assign accept   = in_valid & in_ready & ~flush;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid <= 1'b0;
         npc_o     <= '0;
         ir_o      <= '0;
         a_o       <= '0;
         b_o       <= '0;
         imm_o     <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         npc_o     <= in_npc;
         ir_o      <= in_ir;
         a_o       <= rd_a;
         b_o       <= rd_b;
         imm_o     <= imm_ext;
      end else if (out_valid & out_ready) begin
         // Drained with nothing to replace it (includes the load-use bubble).
         out_valid <= 1'b0;
      end else if (out_valid) begin
         // Held slot: pick up write-backs that land during the stall.
         a_o <= rd_a;
         b_o <= rd_b;
      end
   end

endmodule

// File: tb/tb_id_stage_p.sv
// tb/tb_id_stage_p.sv - self-checking bench for id_stage_p with a behavioural reference model

module tb_id_stage_p;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_npc;
   logic [31:0] in_ir;
   logic        out_valid;
   logic        out_ready;
   logic        flush;
   logic        ex_load;
   logic [4:0]  ex_rd;
   logic        wb_we;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic [31:0] npc_o;
   logic [31:0] a_o;
   logic [31:0] b_o;
   logic [31:0] imm_o;
   logic [31:0] ir_o;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   id_stage_p #(.XLEN(32), .REG_COUNT(32), .ZERO_REG(1)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_npc(in_npc), .in_ir(in_ir),
      .out_valid(out_valid), .out_ready(out_ready), .flush(flush),
      .ex_load(ex_load), .ex_rd(ex_rd),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
      .npc_o(npc_o), .a_o(a_o), .b_o(b_o), .imm_o(imm_o), .ir_o(ir_o)
   );

   // ---------------- reference model ----------------
   logic [31:0] m_regs [32];
   logic        m_valid;
   logic [31:0] m_npc, m_ir, m_a, m_b, m_imm;

   function automatic logic [31:0] exp_imm(input logic [31:0] ir);
      case (ir[31:26])
         6'h0C, 6'h0D, 6'h0E: return 32'(ir[15:0]);
         6'h0F:               return 32'(ir[15:0]) * 32'h0001_0000;
         default:             return 32'($signed(ir[15:0]));
      endcase
   endfunction

   // Value an instruction sees for register r while a write-back is in flight.
   function automatic logic [31:0] model_read(input logic [4:0] r, input logic we,
                                              input logic [4:0] wa, input logic [31:0] wd);
      if (r == 5'd0) return 32'd0;
`ifdef ID_WB_BYPASS_EN
      if (we && wa == r) return wd;
`endif
      return m_regs[r];
   endfunction

   task automatic idle_inputs();
      in_valid = 0; in_npc = 0; in_ir = 0; out_ready = 1; flush = 0;
      ex_load = 0; ex_rd = 0; wb_we = 0; wb_addr = 0; wb_data = 0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // ---------------- directed scenarios ----------------
   task automatic test_reset();
      rst = 0;
      idle_inputs();
      cyc();
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_err++; $display("FAIL reset_valid: got %b want 0", out_valid);
      end
      n_cmp++;
      if ({npc_o, ir_o, a_o, b_o, imm_o} !== 160'd0) begin
         n_err++; $display("FAIL reset_outputs: got %h %h %h %h %h want all 0", npc_o, ir_o, a_o, b_o, imm_o);
      end
      rst = 1;
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_err++; $display("FAIL reset_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_imm();
      in_valid = 1; in_npc = 32'h104; in_ir = 32'h2008FFFF; out_ready = 1;
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_err++; $display("FAIL imm_ready: got %b want 1", in_ready);
      end
      cyc();
      n_cmp++;
      if (out_valid !== 1'b1 || imm_o !== 32'hFFFFFFFF || a_o !== 32'd0 || npc_o !== 32'h104) begin
         n_err++; $display("FAIL addi_capture: got v=%b imm=%h a=%h npc=%h want 1 ffffffff 0 104", out_valid, imm_o, a_o, npc_o);
      end
      in_ir = 32'h3408FFFF; in_npc = 32'h108;
      cyc();
      n_cmp++;
      if (out_valid !== 1'b1 || imm_o !== 32'h0000FFFF) begin
         n_err++; $display("FAIL ori_imm: got v=%b imm=%h want 1 0000ffff", out_valid, imm_o);
      end
      in_ir = 32'h3C081234; in_npc = 32'h10C;
      cyc();
      n_cmp++;
      if (imm_o !== 32'h12340000 || ir_o !== 32'h3C081234) begin
         n_err++; $display("FAIL lui_imm: got imm=%h ir=%h want 12340000 3c081234", imm_o, ir_o);
      end
      in_valid = 0;
      cyc();
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_err++; $display("FAIL drain: got %b want 0", out_valid);
      end
   endtask

   task automatic test_wb_collision();
      in_valid = 1; in_npc = 32'h200; in_ir = 32'h212A0001; out_ready = 1;
      wb_we = 1; wb_addr = 5'd9; wb_data = 32'hDEADBEEF;
      #1;
`ifdef ID_WB_BYPASS_EN
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_err++; $display("FAIL coll_ready: got %b want 1", in_ready);
      end
      cyc();
      wb_we = 0; in_valid = 0;
      n_cmp++;
      if (out_valid !== 1'b1 || a_o !== 32'hDEADBEEF) begin
         n_err++; $display("FAIL coll_bypass: got v=%b a=%h want 1 deadbeef", out_valid, a_o);
      end
`else
      n_cmp++;
      if (in_ready !== 1'b0) begin
         n_err++; $display("FAIL coll_stall_ready: got %b want 0", in_ready);
      end
      cyc();
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_err++; $display("FAIL coll_bubble: got %b want 0", out_valid);
      end
      wb_we = 0;
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_err++; $display("FAIL coll_release: got %b want 1", in_ready);
      end
      cyc();
      in_valid = 0;
      n_cmp++;
      if (out_valid !== 1'b1 || a_o !== 32'hDEADBEEF) begin
         n_err++; $display("FAIL coll_read: got v=%b a=%h want 1 deadbeef", out_valid, a_o);
      end
`endif
      cyc();
   endtask

   task automatic test_load_use();
      in_valid = 1; in_npc = 32'h300; in_ir = 32'h008A1820; ex_load = 1; ex_rd = 5'd10;
      #1;
      n_cmp++;
      if (in_ready !== 1'b0) begin
         n_err++; $display("FAIL lu_ready: got %b want 0", in_ready);
      end
      cyc();
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_err++; $display("FAIL lu_bubble: got %b want 0", out_valid);
      end
      ex_load = 0;
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_err++; $display("FAIL lu_release: got %b want 1", in_ready);
      end
      cyc();
      in_valid = 0;
      n_cmp++;
      if (out_valid !== 1'b1 || ir_o !== 32'h008A1820 || npc_o !== 32'h300) begin
         n_err++; $display("FAIL lu_accept: got v=%b ir=%h npc=%h want 1 008a1820 300", out_valid, ir_o, npc_o);
      end
      cyc();
   endtask

   task automatic test_stall_refresh();
      in_valid = 1; in_npc = 32'h400; in_ir = 32'h20A60007; out_ready = 1;
      cyc();
      n_cmp++;
      if (out_valid !== 1'b1 || a_o !== 32'd0) begin
         n_err++; $display("FAIL hold_fill: got v=%b a=%h want 1 0", out_valid, a_o);
      end
      out_ready = 0; in_npc = 32'h404; in_ir = 32'h3C081234;
      wb_we = 1; wb_addr = 5'd5; wb_data = 32'h55;
      #1;
      n_cmp++;
      if (in_ready !== 1'b0) begin
         n_err++; $display("FAIL hold_ready: got %b want 0", in_ready);
      end
      cyc();
      wb_we = 0;
      cyc();
      n_cmp++;
      if (out_valid !== 1'b1 || a_o !== 32'h55 || ir_o !== 32'h20A60007 || in_ready !== 1'b0) begin
         n_err++; $display("FAIL hold_refresh: got v=%b a=%h ir=%h rdy=%b want 1 55 20a60007 0", out_valid, a_o, ir_o, in_ready);
      end
      out_ready = 1;
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_err++; $display("FAIL hold_release: got %b want 1", in_ready);
      end
      cyc();
      in_valid = 0;
      n_cmp++;
      if (ir_o !== 32'h3C081234 || npc_o !== 32'h404) begin
         n_err++; $display("FAIL hold_next: got ir=%h npc=%h want 3c081234 404", ir_o, npc_o);
      end
      cyc();
   endtask

   task automatic test_flush_zero();
      in_valid = 1; in_npc = 32'h500; in_ir = 32'h2008FFFF; out_ready = 1;
      cyc();
      // Held slot, flush together with a load-use hazard on rt=8.
      out_ready = 0; flush = 1; ex_load = 1; ex_rd = 5'd8;
      in_npc = 32'h504; in_ir = 32'h3408FFFF;
      cyc();
      n_cmp++;
      if (out_valid !== 1'b0 || ir_o === 32'h3408FFFF) begin
         n_err++; $display("FAIL flush: got v=%b ir=%h want 0 and ir not 3408ffff", out_valid, ir_o);
      end
      flush = 0; ex_load = 0; in_valid = 0; out_ready = 1;
      wb_we = 1; wb_addr = 5'd0; wb_data = 32'h1234;
      cyc();
      wb_we = 0; in_valid = 1; in_npc = 32'h508; in_ir = 32'h00000020;
      cyc();
      in_valid = 0;
      n_cmp++;
      if (out_valid !== 1'b1 || a_o !== 32'd0 || b_o !== 32'd0) begin
         n_err++; $display("FAIL zero_reg: got v=%b a=%h b=%h want 1 0 0", out_valid, a_o, b_o);
      end
      cyc();
   endtask

   task automatic test_async_reset();
      in_valid = 1; in_npc = 32'h600; in_ir = 32'h20A60007; out_ready = 1;
      cyc();
      out_ready = 0; ex_load = 1; ex_rd = 5'd6; in_ir = 32'h00C00020;
      #2;
      rst = 0;
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || {npc_o, ir_o, a_o} !== 96'd0) begin
         n_err++; $display("FAIL async_reset: got v=%b npc=%h ir=%h a=%h want all 0", out_valid, npc_o, ir_o, a_o);
      end
      idle_inputs();
      rst = 1;
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_err++; $display("FAIL reset_residual_ready: got %b want 1", in_ready);
      end
      in_valid = 1; in_npc = 32'h610; in_ir = 32'h20A60007;
      cyc();
      in_valid = 0;
      n_cmp++;
      if (out_valid !== 1'b1 || a_o !== 32'd0) begin
         n_err++; $display("FAIL reset_regs: got v=%b a=%h want 1 0", out_valid, a_o);
      end
      cyc();
   endtask

   // ---------------- randomized run against the model ----------------
   task automatic test_random();
      logic [5:0]  ops [7] = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23};
      logic        hz, exp_rdy, accept;
      logic [4:0]  rs, rt;
      logic [31:0] na, nb;
      rst = 0;
      idle_inputs();
      cyc();
      rst = 1;
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_valid = 0; m_npc = 0; m_ir = 0; m_a = 0; m_b = 0; m_imm = 0;
      for (int c = 0; c < 500; c++) begin
         rs = 5'($urandom_range(0, 7));
         rt = 5'($urandom_range(0, 7));
         in_valid  = ($urandom_range(0, 3) != 0);
         in_ir     = {ops[$urandom_range(0, 6)], rs, rt, 16'($urandom)};
         in_npc    = $urandom;
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 9) == 0);
         ex_load   = ($urandom_range(0, 3) == 0);
         ex_rd     = 5'($urandom_range(0, 7));
         wb_we     = ($urandom_range(0, 1) != 0);
         wb_addr   = 5'($urandom_range(0, 7));
         wb_data   = $urandom;
         #1;
         hz = in_valid && ex_load && ex_rd != 0 && (ex_rd == rs || ex_rd == rt);
`ifndef ID_WB_BYPASS_EN
         hz = hz || (in_valid && wb_we && wb_addr != 0 && (wb_addr == rs || wb_addr == rt));
`endif
         exp_rdy = !hz && (!m_valid || out_ready);
         n_cmp++;
         if (in_ready !== exp_rdy) begin
            n_err++; $display("FAIL rnd_ready cycle %0d: got %b want %b", c, in_ready, exp_rdy);
         end
         accept = in_valid && exp_rdy && !flush;
         if (flush) begin
            m_valid = 0;
         end else if (accept) begin
            m_valid = 1; m_npc = in_npc; m_ir = in_ir; m_imm = exp_imm(in_ir);
            m_a = model_read(rs, wb_we, wb_addr, wb_data);
            m_b = model_read(rt, wb_we, wb_addr, wb_data);
         end else if (m_valid && out_ready) begin
            m_valid = 0;
         end else if (m_valid) begin
            na = model_read(m_ir[25:21], wb_we, wb_addr, wb_data);
            nb = model_read(m_ir[20:16], wb_we, wb_addr, wb_data);
            m_a = na; m_b = nb;
         end
         if (wb_we && wb_addr != 0) m_regs[wb_addr] = wb_data;
         cyc();
         n_cmp++;
         if (out_valid !== m_valid) begin
            n_err++; $display("FAIL rnd_valid cycle %0d: got %b want %b", c, out_valid, m_valid);
         end
         if (m_valid) begin
            n_cmp++;
            if (npc_o !== m_npc || ir_o !== m_ir || imm_o !== m_imm) begin
               n_err++; $display("FAIL rnd_slot cycle %0d: got npc=%h ir=%h imm=%h want %h %h %h", c, npc_o, ir_o, imm_o, m_npc, m_ir, m_imm);
            end
            n_cmp++;
            if (a_o !== m_a || b_o !== m_b) begin
               n_err++; $display("FAIL rnd_ab cycle %0d: got a=%h b=%h want %h %h", c, a_o, b_o, m_a, m_b);
            end
         end
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_imm();
      test_wb_collision();
      test_load_use();
      test_stall_refresh();
      test_flush_zero();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
